word_gen_op_ctrl: RTL and testbench



---
 rtl/word_gen_op_ctrl_pkg.sv | 18 +
 rtl/word_gen_carry_chain.sv | 37 +++
 rtl/word_gen_op_ctrl.sv | 130 +++++++++++++
 tb/tb_word_gen_op_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_gen_op_ctrl_pkg.sv
// Shared constants for the word generator: the operation state encoding
// seen by both this controller and the per-position range stages, and the
// default for the optional extra register stage.
package word_gen_op_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_STATE_READY       = 3'd0,
    OP_STATE_START       = 3'd1,
    OP_STATE_EXTRA_STAGE = 3'd2,
    OP_STATE_NEXT_CHAR   = 3'd3,
    OP_STATE_NEXT_WORD   = 3'd4,  // reserved, never driven by the controller
    OP_STATE_DONE        = 3'd5
  } op_state_e;

  localparam int EXTRA_REGISTER_STAGE_DEFAULT = 1;
  localparam int NUM_RANGES_BITS              = 4;

endpackage

// File: rtl/word_gen_carry_chain.sv
// Prefix-AND carry chain across the range stages.
//   load         : advance request for the fastest position (range 0)
//   num_ranges   : number of active ranges; positions at or above it are masked
//   range_carry  : per-range "at last char" flags
//   active       : per-range active mask
//   carry_in     : per-range advance enable
//   all_carry    : every active range is at its last char (final combination)
module word_gen_carry_chain #(
  parameter int RANGES_MAX = 8,
  parameter int NR_BITS    = 4
) (
  input  logic                  load,
  input  logic [NR_BITS-1:0]    num_ranges,
  input  logic [RANGES_MAX-1:0] range_carry,
  output logic [RANGES_MAX-1:0] active,
  output logic [RANGES_MAX-1:0] carry_in,
  output logic                  all_carry
);

  logic chain;

  always_comb begin
    active    = '0;
    carry_in  = '0;
    all_carry = 1'b1;
    chain     = load;
    for (int i = 0; i < RANGES_MAX; i++) begin
      if (i < int'(num_ranges)) begin
        active[i]   = 1'b1;
        carry_in[i] = chain;
        chain       = chain & range_carry[i];
        all_carry   = all_carry & range_carry[i];
      end
    end
  end

endmodule

// File: rtl/word_gen_op_ctrl.sv
// Operation controller and word assembler for the range stages.
// Sequences op_state/op_en/carry_in into the ranges, captures their dout
// buses into a registered word with a valid/rd_en handshake, and returns
// the ranges to READY after the final combination.
//   OP_CLK, rstb   : clock, synchronous active-high reset
//   start          : start pulse (accepted in READY only)
//   num_ranges     : active range count, sampled on accepted start
//   op_state/op_en/carry_in : control to the range stages
//   range_carry/range_dout  : status/data from the range stages
//   word/word_valid/word_last/word_rd_en : output word handshake
//   op_done        : one-cycle completion pulse
//   word_count     : words emitted since the last accepted start
//
// state       | meaning
// READY       | idle, waiting for start
// START       | ranges reset to their first char
// EXTRA_STAGE | one cycle for the ranges' extra register stage
// NEXT_CHAR   | load a word whenever the output register is free
// DONE        | final word loaded, op_done pulse
module word_gen_op_ctrl
  import word_gen_op_ctrl_pkg::*;
#(
  parameter int CHAR_BITS            = 7,
  parameter int RANGES_MAX           = 8,
  parameter int EXTRA_REGISTER_STAGE = EXTRA_REGISTER_STAGE_DEFAULT,
  parameter int COUNT_BITS           = 32
) (
  input  logic                             OP_CLK,
  input  logic                             rstb,
  input  logic                             start,
  input  logic [NUM_RANGES_BITS-1:0]       num_ranges,
  output logic [2:0]                       op_state,
  output logic                             op_en,
  output logic [RANGES_MAX-1:0]            carry_in,
  input  logic [RANGES_MAX-1:0]            range_carry,
  input  logic [RANGES_MAX*CHAR_BITS-1:0]  range_dout,
  output logic [RANGES_MAX*CHAR_BITS-1:0]  word,
  output logic                             word_valid,
  output logic                             word_last,
  input  logic                             word_rd_en,
  output logic                             op_done,
  output logic [COUNT_BITS-1:0]            word_count
);

  localparam int WORD_W = RANGES_MAX * CHAR_BITS;

  op_state_e                  state_q, state_d;
  logic [NUM_RANGES_BITS-1:0] nr_q;
  logic                       load;
  logic                       all_carry;
  logic [RANGES_MAX-1:0]      active;
  logic [WORD_W-1:0]          word_d;

  // The output register is free when empty or being read this cycle.
  assign load = (state_q == OP_STATE_NEXT_CHAR) && (!word_valid || word_rd_en);

  word_gen_carry_chain #(
    .RANGES_MAX (RANGES_MAX),
    .NR_BITS    (NUM_RANGES_BITS)
  ) u_carry_chain (
    .load        (load),
    .num_ranges  (nr_q),
    .range_carry (range_carry),
    .active      (active),
    .carry_in    (carry_in),
    .all_carry   (all_carry)
  );

  always_comb begin
    word_d = '0;
    for (int i = 0; i < RANGES_MAX; i++) begin
      if (active[i]) begin
        word_d[i*CHAR_BITS +: CHAR_BITS] = range_dout[i*CHAR_BITS +: CHAR_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OP_STATE_READY: begin
        if (start) begin
          state_d = (num_ranges == '0) ? OP_STATE_DONE : OP_STATE_START;
        end
      end
      OP_STATE_START: begin
        state_d = (EXTRA_REGISTER_STAGE != 0) ? OP_STATE_EXTRA_STAGE
                                              : OP_STATE_NEXT_CHAR;
      end
      OP_STATE_EXTRA_STAGE: state_d = OP_STATE_NEXT_CHAR;
      OP_STATE_NEXT_CHAR: begin
        // The ranges wrap on the final advance; nothing reads them afterwards.
        if (load && all_carry) state_d = OP_STATE_DONE;
      end
      OP_STATE_DONE: state_d = OP_STATE_READY;
      default:       state_d = OP_STATE_READY;
    endcase
  end

  assign op_state = state_q;
  assign op_en    = load;
  assign op_done  = (state_q == OP_STATE_DONE);

  always_ff @(posedge OP_CLK) begin
    if (rstb) begin
      state_q    <= OP_STATE_READY;
      nr_q       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == OP_STATE_READY && start) begin
        word_count <= '0;
        if (num_ranges != '0) nr_q <= num_ranges;
      end
      if (load) begin
        word       <= word_d;
        word_valid <= 1'b1;
        word_last  <= all_carry;
        word_count <= word_count + COUNT_BITS'(1);
      end else if (word_valid && word_rd_en) begin
        word_valid <= 1'b0;
        word_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_gen_op_ctrl.sv
// Bench for word_gen_op_ctrl: two instances (extra stage on/off) driven by
// the same stimulus, each with behavioural range stages, checked against a
// mixed-radix enumeration of the expected word sequence.
module tb_word_gen_op_ctrl;

  localparam int RM = 8;
  localparam int CB = 7;
  localparam int W  = RM * CB;

  logic OP_CLK = 1'b0;
  logic rstb, start, word_rd_en;
  logic [3:0] num_ranges;

  logic [1:0][2:0]    op_state;
  logic [1:0]         op_en, word_valid, word_last, op_done;
  logic [1:0][RM-1:0] carry_in, range_carry;
  logic [1:0][W-1:0]  range_dout, word;
  logic [1:0][31:0]   word_count;

  always #5 OP_CLK = ~OP_CLK;

  word_gen_op_ctrl #(.CHAR_BITS(CB), .RANGES_MAX(RM), .EXTRA_REGISTER_STAGE(1), .COUNT_BITS(32)) u_dut0 (
    .OP_CLK(OP_CLK), .rstb(rstb), .start(start), .num_ranges(num_ranges),
    .op_state(op_state[0]), .op_en(op_en[0]), .carry_in(carry_in[0]),
    .range_carry(range_carry[0]), .range_dout(range_dout[0]),
    .word(word[0]), .word_valid(word_valid[0]), .word_last(word_last[0]),
    .word_rd_en(word_rd_en), .op_done(op_done[0]), .word_count(word_count[0]));

  word_gen_op_ctrl #(.CHAR_BITS(CB), .RANGES_MAX(RM), .EXTRA_REGISTER_STAGE(0), .COUNT_BITS(32)) u_dut1 (
    .OP_CLK(OP_CLK), .rstb(rstb), .start(start), .num_ranges(num_ranges),
    .op_state(op_state[1]), .op_en(op_en[1]), .carry_in(carry_in[1]),
    .range_carry(range_carry[1]), .range_dout(range_dout[1]),
    .word(word[1]), .word_valid(word_valid[1]), .word_last(word_last[1]),
    .word_rd_en(word_rd_en), .op_done(op_done[1]), .word_count(word_count[1]));

  // Range configuration: per position a char list and its length.
  logic [CB-1:0] rchars [RM][RM];
  int            rlen   [RM];

  // Behavioural range stages: index resets on START, advances on op_en & carry_in.
  logic [1:0][RM-1:0][2:0] idx;

  always @(posedge OP_CLK) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < RM; i++) begin
        if (rstb || op_state[d] == 3'd1) idx[d][i] <= 3'd0;
        else if (op_en[d] && carry_in[d][i])
          idx[d][i] <= (idx[d][i] == 3'(rlen[i] - 1)) ? 3'd0 : idx[d][i] + 3'd1;
      end
    end
  end

  always_comb begin
    range_carry = '0;
    range_dout  = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < RM; i++) begin
        range_carry[d][i]           = (idx[d][i] == 3'(rlen[i] - 1));
        range_dout[d][i*CB +: CB]   = rchars[i][idx[d][i]];
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: actual=%0h expected=%0h", d, name, act, exp);
    end
  endtask

  // Scoreboard state
  logic [W-1:0] exp_w [64];
  int           total = 0;
  logic [RM-1:0] amask = '0;
  int           rd_ptr [2];
  int           ndone  [2];
  int           lat    [2];
  int           since  [2];
  logic         pv [2];
  logic         pc [2];
  logic [W-1:0] pword [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_ptr[d] = 0; ndone[d] = 0; lat[d] = -1; since[d] = 0;
      pv[d] = 1'b0; pc[d] = 1'b0; pword[d] = '0;
    end
  end

  always @(negedge OP_CLK) begin
    if (rstb) begin
      for (int d = 0; d < 2; d++) begin pv[d] = 1'b0; pc[d] = 1'b0; end
    end else begin
      if (start) begin
        // Enumerate every combination, range 0 as the least significant digit.
        total = (num_ranges == 4'd0) ? 0 : 1;
        for (int i = 0; i < int'(num_ranges); i++) total = total * rlen[i];
        for (int n = 0; n < total; n++) begin
          int rem;
          logic [W-1:0] w;
          rem = n;
          w   = '0;
          for (int i = 0; i < int'(num_ranges); i++) begin
            w   = w | (W'(rchars[i][rem % rlen[i]]) << (i * CB));
            rem = rem / rlen[i];
          end
          exp_w[n] = w;
        end
        amask = RM'((1 << num_ranges) - 1);
        for (int d = 0; d < 2; d++) begin rd_ptr[d] = 0; ndone[d] = 0; lat[d] = -1; end
      end
      for (int d = 0; d < 2; d++) begin
        since[d] = start ? -1 : since[d] + 1;
        if (word_valid[d] && (!pv[d] || pc[d])) begin
          if (lat[d] < 0) lat[d] = since[d];
          if (rd_ptr[d] < total) begin
            chk(d, "word", 64'(word[d]), 64'(exp_w[rd_ptr[d]]));
            chk(d, "word_last", 64'(word_last[d]), 64'(rd_ptr[d] == total - 1));
            chk(d, "word_count", 64'(word_count[d]), 64'(rd_ptr[d] + 1));
          end else begin
            chk(d, "extra_word", 64'(rd_ptr[d] + 1), 64'(total));
          end
          rd_ptr[d]++;
        end else if (word_valid[d] && pv[d]) begin
          chk(d, "word_hold", 64'(word[d]), 64'(pword[d]));
        end
        if (word_valid[d] && !word_rd_en) chk(d, "op_en_stall", 64'(op_en[d]), 64'd0);
        chk(d, "inactive_carry", 64'(carry_in[d] & ~amask), 64'd0);
        chk(d, "no_next_word", 64'(op_state[d] == 3'd4), 64'd0);
        if (op_done[d]) begin
          ndone[d]++;
          chk(d, "done_after_last", 64'(rd_ptr[d]), 64'(total));
        end
        pv[d]    = word_valid[d];
        pc[d]    = word_valid[d] && word_rd_en;
        pword[d] = word[d];
      end
    end
  end

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk(d, {tag, "_op_state"},   64'(op_state[d]),   64'd0);
      chk(d, {tag, "_op_en"},      64'(op_en[d]),      64'd0);
      chk(d, {tag, "_carry_in"},   64'(carry_in[d]),   64'd0);
      chk(d, {tag, "_word_valid"}, 64'(word_valid[d]), 64'd0);
      chk(d, {tag, "_word_last"},  64'(word_last[d]),  64'd0);
      chk(d, {tag, "_word"},       64'(word[d]),       64'd0);
      chk(d, {tag, "_op_done"},    64'(op_done[d]),    64'd0);
      chk(d, {tag, "_word_count"}, 64'(word_count[d]), 64'd0);
    end
  endtask

  task automatic pulse_start();
    @(posedge OP_CLK); #1 start = 1'b1;
    @(posedge OP_CLK); #1 start = 1'b0;
  endtask

  // Start and wait for both instances to finish and drain; optional stall
  // of stall_cycles with word_rd_en low after the first word appears.
  task automatic run(input int stall_cycles);
    int hold;
    hold = 0;
    word_rd_en = (stall_cycles == 0);
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      @(posedge OP_CLK); #1;
      if (stall_cycles > 0 && hold < stall_cycles && word_valid[0]) begin
        hold++;
        chk(0, "stall_word", 64'(word[0]), 64'h3C61);
        chk(1, "stall_word", 64'(word[1]), 64'h3C61);
        chk(0, "stall_op_en", 64'(op_en[0]), 64'd0);
      end else if (hold == stall_cycles) begin
        word_rd_en = 1'b1;
      end
      if (ndone[0] > 0 && ndone[1] > 0 && !word_valid[0] && !word_valid[1]) break;
    end
    for (int d = 0; d < 2; d++) chk(d, "done_pulses", 64'(ndone[d]), 64'd1);
  endtask

  task automatic cfg_ab_xyz();
    for (int i = 0; i < RM; i++) begin
      rlen[i] = 1;
      for (int j = 0; j < RM; j++) rchars[i][j] = '0;
    end
    rlen[0] = 2; rchars[0][0] = 7'h61; rchars[0][1] = 7'h62;
    rlen[1] = 3; rchars[1][0] = 7'h78; rchars[1][1] = 7'h79; rchars[1][2] = 7'h7A;
    num_ranges = 4'd2;
  endtask

  initial begin
    rstb = 1'b1; start = 1'b0; word_rd_en = 1'b1; num_ranges = 4'd0;
    cfg_ab_xyz();
    repeat (3) @(posedge OP_CLK);
    #1 chk_reset("reset");
    rstb = 1'b0;

    // Basic 6-word sequence, continuous read.
    run(0);
    chk(0, "model_first_ax", 64'(exp_w[0]), 64'h3C61);
    chk(0, "model_last_bz",  64'(exp_w[5]), 64'h3D62);
    for (int d = 0; d < 2; d++) begin
      chk(d, "runA_words", 64'(rd_ptr[d]), 64'd6);
      chk(d, "runA_count", 64'(word_count[d]), 64'd6);
      chk(d, "runA_last_word", 64'(word[d]), 64'h3D62);
    end
    chk(0, "latency_extra1", 64'(lat[0]), 64'd3);
    chk(1, "latency_extra0", 64'(lat[1]), 64'd2);

    // Consumer stall for 5 cycles after the first word.
    run(5);
    for (int d = 0; d < 2; d++) chk(d, "stall_words", 64'(rd_ptr[d]), 64'd6);

    // num_ranges = 0: straight to DONE, no words.
    num_ranges = 4'd0;
    pulse_start();
    for (int d = 0; d < 2; d++) begin
      chk(d, "nr0_op_done",    64'(op_done[d]),    64'd1);
      chk(d, "nr0_op_state",   64'(op_state[d]),   64'd5);
      chk(d, "nr0_word_valid", 64'(word_valid[d]), 64'd0);
    end
    @(posedge OP_CLK); #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "nr0_done_clear", 64'(op_done[d]),    64'd0);
      chk(d, "nr0_ready",      64'(op_state[d]),   64'd0);
      chk(d, "nr0_count",      64'(word_count[d]), 64'd0);
    end

    // Single range with a single char.
    rlen[0] = 1; rchars[0][0] = 7'h71; num_ranges = 4'd1;
    run(0);
    for (int d = 0; d < 2; d++) begin
      chk(d, "single_words", 64'(rd_ptr[d]), 64'd1);
      chk(d, "single_count", 64'(word_count[d]), 64'd1);
      chk(d, "single_word",  64'(word[d]), 64'h71);
    end

    // Reset mid-sequence, then a clean rerun.
    cfg_ab_xyz();
    word_rd_en = 1'b1;
    pulse_start();
    for (int c = 0; c < 50; c++) begin
      @(posedge OP_CLK); #1;
      if (rd_ptr[0] >= 3) break;
    end
    chk(0, "abort_progress", 64'(rd_ptr[0] >= 3), 64'd1);
    rstb = 1'b1;
    @(posedge OP_CLK); #1 chk_reset("midreset");
    rstb = 1'b0;
    repeat (4) @(posedge OP_CLK);
    #1;
    for (int d = 0; d < 2; d++) chk(d, "abort_no_done", 64'(ndone[d]), 64'd0);
    run(0);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rerun_words", 64'(rd_ptr[d]), 64'd6);
      chk(d, "rerun_count", 64'(word_count[d]), 64'd6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
